bcd_convert_ctrl: RTL and testbench

Sequential binary-to-BCD converter controller for the two-mode timer display path. It sequences the shift-and-add-3 (double-dabble) algorithm one bit per clock, reusing one add-3-if-greater-than-4 digit cell per BCD digit. It uses a start/done handshake, so the timer core can request a conversion whenever its count changes.

---
 rtl/bcd_convert_ctrl_if.sv | 31 +++
 rtl/bcd_convert_ctrl.sv | 135 +++++++++++++
 tb/tb_bcd_convert_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_ctrl_if.sv
// ============================================================================
// bcd_convert_ctrl_if : start/done handshake and result bus of the BCD converter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface bcd_convert_ctrl_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  ovf;
   logic [DIGITS-1:0]     blank;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, ovf, blank
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, ovf, blank
   );
endinterface

`default_nettype wire

// File: rtl/bcd_convert_ctrl.sv
// ============================================================================
// bcd_convert_ctrl : sequential double-dabble binary-to-BCD converter, one bit
// per clock. Optional macro BCD_LEADING_BLANK_EN enables the leading-zero mask.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_convert_ctrl #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3,
   parameter int CNT_W  = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   bcd_convert_ctrl_if.slave bus
);

   localparam int               W    = 4 * DIGITS;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BIN_W-1:0]  shift_q;
   logic [W-1:0]      work_q;
   logic              sticky;
   logic              busy_q;
   logic              done_q;
   logic              ovf_q;
   logic [W-1:0]      bcd_q;

   logic [W-1:0]      work_adj;
   logic [W-1:0]      work_nxt;
   logic [BIN_W-1:0]  shift_nxt;
   logic              out_bit;

   // Digits are adjusted independently; the +3 wraps inside its own nibble.
   always_comb begin
      work_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         work_adj[4*i +: 4] = (work_q[4*i +: 4] > 4'd4) ? (work_q[4*i +: 4] + 4'd3)
                                                        : work_q[4*i +: 4];
      end
      {out_bit, work_nxt, shift_nxt} = {work_adj, shift_q, 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         shift_q <= '0;
         work_q  <= '0;
         sticky  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  shift_q <= bus.bin_in;
                  work_q  <= '0;
                  cnt     <= '0;
                  sticky  <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= S_CONV;
               end else begin
                  busy_q  <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            S_CONV: begin
               work_q  <= work_nxt;
               shift_q <= shift_nxt;
               sticky  <= sticky | out_bit;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // Result is published on the same edge as the final shift.
                  bcd_q  <= work_nxt;
                  ovf_q  <= sticky | out_bit;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.bcd_out = bcd_q;
   assign bus.ovf     = ovf_q;

`ifdef BCD_LEADING_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic [DIGITS-1:0] blank_q;

   // Digit 0 is never blanked so a zero result still shows one "0".
   for (genvar k = 0; k < DIGITS; k++) begin : g_blank
      if (k == 0) begin : g_lsd
         assign blank_nxt[k] = 1'b0;
      end else begin : g_upper
         assign blank_nxt[k] = (work_nxt[W-1:4*k] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= '0;
      end else if (state == S_CONV && cnt == LAST) begin
         blank_q <= blank_nxt;
      end
   end

   assign bus.blank = blank_q;
`else
   assign bus.blank = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_convert_ctrl.sv
// ============================================================================
// tb_bcd_convert_ctrl : randomized self-checking bench for bcd_convert_ctrl
// with 8-bit and 10-bit instances against an arithmetic reference model.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_convert_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bcd_convert_ctrl_if #(.BIN_W(8),  .DIGITS(3)) b8 ();
   bcd_convert_ctrl_if #(.BIN_W(10), .DIGITS(3)) b10 ();

   bcd_convert_ctrl #(.BIN_W(8),  .DIGITS(3), .CNT_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   bcd_convert_ctrl #(.BIN_W(10), .DIGITS(3), .CNT_W(4)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: decimal digits of the value modulo 1000.
   function automatic logic [11:0] bcd_of(input int v);
      int m;
      m = v % 1000;
      return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   function automatic logic [2:0] blank_of(input int v);
      logic [2:0] b;
      int m;
      m = v % 1000;
      b = 3'b000;
`ifdef BCD_LEADING_BLANK_EN
      b[2] = (m < 100);
      b[1] = (m < 10);
`endif
      return b;
   endfunction

   task automatic conv8(input int val);
      int lat, bc;
      @(negedge clk);
      b8.start  = 1'b1;
      b8.bin_in = 8'(val);
      lat = 0;
      bc  = 0;
      do begin
         @(negedge clk);
         b8.start  = 1'b0;
         b8.bin_in = 8'($urandom);
         lat++;
         if (b8.busy) bc++;
      end while (!b8.done && lat < 40);
      check("lat8",   lat, 9);
      check("busy8",  bc, 8);
      check("bcd8",   b8.bcd_out, bcd_of(val));
      check("ovf8",   b8.ovf, 1'b0);
      check("blank8", b8.blank, blank_of(val));
      @(negedge clk);
      check("pulse8", b8.done, 1'b0);
      check("hold8",  b8.bcd_out, bcd_of(val));
   endtask

   task automatic conv10(input int val);
      int lat, bc;
      @(negedge clk);
      b10.start  = 1'b1;
      b10.bin_in = 10'(val);
      lat = 0;
      bc  = 0;
      do begin
         @(negedge clk);
         b10.start  = 1'b0;
         b10.bin_in = 10'($urandom);
         lat++;
         if (b10.busy) bc++;
      end while (!b10.done && lat < 40);
      check("lat10",   lat, 11);
      check("busy10",  bc, 10);
      check("bcd10",   b10.bcd_out, bcd_of(val));
      check("ovf10",   b10.ovf, (val >= 1000));
      check("blank10", b10.blank, blank_of(val));
      @(negedge clk);
      check("pulse10", b10.done, 1'b0);
   endtask

   initial begin
      int dones, last, at;
      logic [11:0] seen;

      rst_n      = 1'b0;
      b8.start   = 1'b0;
      b8.bin_in  = '0;
      b10.start  = 1'b0;
      b10.bin_in = '0;
      repeat (2) @(negedge clk);
      check("rst_busy",  b8.busy, 1'b0);
      check("rst_done",  b8.done, 1'b0);
      check("rst_bcd",   b8.bcd_out, 12'h000);
      check("rst_ovf",   b8.ovf, 1'b0);
      check("rst_blank", b8.blank, 3'b000);
      check("rst_busy10", b10.busy, 1'b0);
      rst_n = 1'b1;

      conv8(0);
      conv8(255);

      // Start held high: back-to-back conversions every BIN_W+1 cycles.
      @(negedge clk);
      b8.start  = 1'b1;
      b8.bin_in = 8'd99;
      dones = 0;
      last  = 0;
      for (int i = 1; i <= 28; i++) begin
         @(negedge clk);
         if (b8.done) begin
            dones++;
            check("b2b_gap",   i - last, 9);
            check("b2b_bcd",   b8.bcd_out, bcd_of(99));
            check("b2b_blank", b8.blank, blank_of(99));
            last = i;
         end
      end
      b8.start = 1'b0;
      check("b2b_cnt", dones, 3);
      repeat (12) @(negedge clk);

      // Start pulses and bin_in changes during CONV must be ignored.
      @(negedge clk);
      b8.start  = 1'b1;
      b8.bin_in = 8'd37;
      @(negedge clk);
      b8.start  = 1'b0;
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         b8.start  = 1'b1;
         b8.bin_in = 8'd200;
      end
      @(negedge clk);
      b8.start = 1'b0;
      dones = 0;
      at    = 0;
      seen  = '0;
      for (int i = 7; i <= 22; i++) begin
         @(negedge clk);
         if (b8.done) begin
            dones++;
            at   = i;
            seen = b8.bcd_out;
         end
      end
      check("ign_cnt", dones, 1);
      check("ign_at",  at, 9);
      check("ign_bcd", seen, bcd_of(37));

      // Asynchronous reset mid-conversion.
      @(negedge clk);
      b8.start  = 1'b1;
      b8.bin_in = 8'd128;
      @(negedge clk);
      b8.start  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("ar_busy",  b8.busy, 1'b0);
      check("ar_done",  b8.done, 1'b0);
      check("ar_bcd",   b8.bcd_out, 12'h000);
      check("ar_ovf",   b8.ovf, 1'b0);
      check("ar_blank", b8.blank, 3'b000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (b8.done) dones++;
      end
      check("ar_nodone", dones, 0);
      conv8(128);

      for (int i = 0; i < 30; i++) conv8(int'($urandom_range(0, 255)));

      conv10(999);
      conv10(1000);
      conv10(0);
      conv10(1023);
      for (int i = 0; i < 15; i++) conv10(int'($urandom_range(0, 1023)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
